// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the IF/ID stage controller.
package riscv_pipe_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: hold, sequential increment, or word-aligned branch redirect.
module pc_reg
  import riscv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            pc_write_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Next PC; the increment wraps silently at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (run_i && pc_write_i) begin
      if (redirect_i) begin
        pc_d = {target_i[XLEN-1:2], 2'b00};
      end else begin
        pc_d = pc_q + XLEN'(4);
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_id_stage_ctrl.sv
// PC and IF/ID register owner applying stall, flush and redirect controls.
// Optional IF_ID_PERF_CNT_EN adds saturating stall/flush event counters.
module if_id_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            pc_write_i,
  input  logic            if_id_write_i,
  input  logic            if_id_flush_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [31:0]     if_id_instr_o,
  output logic            if_id_valid_o
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  localparam if_id_t IF_ID_BUBBLE = '{pc: {XLEN{1'b0}}, instr: NOP_INSTR, valid: 1'b0};

  state_e state_d, state_q;
  if_id_t if_id_d, if_id_q;
  logic   run_s;
  logic   stall_s;
  logic   flush_s;

  assign run_s   = (state_q == S_RUN);
  // A stalled cycle drops the flush; the branch resolves again once ID moves.
  assign stall_s = run_s && !if_id_write_i;
  assign flush_s = run_s && if_id_write_i && if_id_flush_i;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (run_s),
    .pc_write_i (pc_write_i),
    .redirect_i (flush_s),
    .target_i   (branch_target_i),
    .pc_o       (pc_o)
  );

  // Sequencing FSM and IF/ID next-state selection.
  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!if_id_write_i) begin
          if_id_d = if_id_q;
        end else if (if_id_flush_i) begin
          if_id_d = IF_ID_BUBBLE;
        end else begin
          if_id_d = '{pc: pc_o, instr: instr_i, valid: 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        if_id_d = IF_ID_BUBBLE;
      end
    endcase
  end

  // FSM state and IF/ID pipeline register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
    end
  end

  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_s;
  assign unused_s = stall_s;
`endif

endmodule
